// File: rtl/jk_ff_s_core.sv
// jk_ff_s_core: bank of WIDTH independent positive-edge JK flip-flops.
// Asynchronous active-high reset clears every cell. qb is always ~q.
// Optional feature macro: JK_FF_S_TOGGLE_CNT_EN adds toggle_cnt[CNT_W-1:0],
// which counts the q bits that flip on each clock edge and wraps modulo 2^CNT_W.
module jk_ff_s_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             reset,
  input  logic             clk,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef JK_FF_S_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  // Reject parameter values that leave a zero-width bank or counter.
  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("jk_ff_s_core: WIDTH and CNT_W must both be >= 1");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;

  // Per-cell JK next-state decode: hold, clear, set or toggle.
  always_comb begin
    q_next_s = q_r;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   q_next_s[i] = q_r[i];
        2'b01:   q_next_s[i] = 1'b0;
        2'b10:   q_next_s[i] = 1'b1;
        2'b11:   q_next_s[i] = ~q_r[i];
        default: q_next_s[i] = q_r[i];
      endcase
    end
  end

  // Cell state register; reset wins over a coincident clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q  = q_r;
  // The complement is derived from q rather than stored in a second flop, so q and qb can never disagree.
  assign qb = ~q_r;

`ifdef JK_FF_S_TOGGLE_CNT_EN
  logic [CNT_W-1:0] toggle_cnt_r;
  logic [CNT_W-1:0] flips_s;

  // Count the set bits of a flip mask; the sum wraps at the counter width.
  function automatic logic [CNT_W-1:0] count_ones(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  // Count the cells whose q changes value on this edge.
  always_comb begin
    flips_s = count_ones(q_next_s ^ q_r);
  end

  // Toggle event counter, cleared together with the cells.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_cnt_r <= {CNT_W{1'b0}};
    end else begin
      toggle_cnt_r <= toggle_cnt_r + flips_s;
    end
  end

  assign toggle_cnt = toggle_cnt_r;
`endif

endmodule

// File: tb/tb_jk_ff_s_core.sv
// Directed, table-driven bench for jk_ff_s_core (scalar and 4-bit banks).
module tb_jk_ff_s_core;

  logic       clk;
  logic       rst1, rst4;
  logic [0:0] j1, k1, q1, qb1;
  logic [3:0] j4, k4, q4, qb4;
`ifdef JK_FF_S_TOGGLE_CNT_EN
  logic [1:0] cnt1;
  logic [7:0] cnt4;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] exp_q;
  } vec_t;

  vec_t v1[10];
  vec_t v4[6];

  jk_ff_s_core #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .reset(rst1), .clk(clk), .j(j1), .k(k1), .q(q1), .qb(qb1)
`ifdef JK_FF_S_TOGGLE_CNT_EN
    , .toggle_cnt(cnt1)
`endif
  );

  jk_ff_s_core #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .reset(rst4), .clk(clk), .j(j4), .k(k4), .q(q4), .qb(qb4)
`ifdef JK_FF_S_TOGGLE_CNT_EN
    , .toggle_cnt(cnt4)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic [3:0] exp_q);
    check({name, " q"}, {3'b000, q1}, exp_q);
    check({name, " qb"}, {3'b000, qb1}, {3'b000, ~exp_q[0]});
  endtask

  initial begin
    // Scalar sequence starting from q=0: set, hold x3, clear, toggle, toggle, clear, set, clear.
    v1[0] = '{4'd1, 4'd0, 4'd1};
    v1[1] = '{4'd0, 4'd0, 4'd1};
    v1[2] = '{4'd0, 4'd0, 4'd1};
    v1[3] = '{4'd0, 4'd0, 4'd1};
    v1[4] = '{4'd0, 4'd1, 4'd0};
    v1[5] = '{4'd1, 4'd1, 4'd1};
    v1[6] = '{4'd1, 4'd1, 4'd0};
    v1[7] = '{4'd0, 4'd1, 4'd0};
    v1[8] = '{4'd1, 4'd0, 4'd1};
    v1[9] = '{4'd0, 4'd1, 4'd0};
    // 4-bit sequence from 0000. Bit3 set, bit2 clear, bit1 toggle, bit0 hold -> 1010.
    v4[0] = '{4'b1010, 4'b0110, 4'b1010};
    v4[1] = '{4'b0000, 4'b0000, 4'b1010};
    v4[2] = '{4'b1111, 4'b1111, 4'b0101};
    v4[3] = '{4'b0011, 4'b1100, 4'b0011};
    v4[4] = '{4'b0101, 4'b0101, 4'b0110};
    v4[5] = '{4'b0000, 4'b1111, 4'b0000};

    rst1 = 1'b1; rst4 = 1'b1;
    j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    #1;
    check1("reset before edge", 4'd0);
    check("reset4 q", q4, 4'b0000);
    check("reset4 qb", qb4, 4'b1111);

    // t=4: release reset and toggle on every edge.
    #3;
    rst1 = 1'b0; rst4 = 1'b0;
    j1 = 1'b1; k1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check1($sformatf("toggle edge %0d", i), (i % 2 == 0) ? 4'd1 : 4'd0);
    end

    // Set to 1, then raise reset mid-cycle; q must clear before the next edge.
    j1 = 1'b1; k1 = 1'b0;
    @(posedge clk); #1;
    check1("set before async reset", 4'd1);
    #2;
    rst1 = 1'b1;
    #1;
    check1("async reset mid-cycle", 4'd0);
    j1 = 1'b0; k1 = 1'b1;
    @(posedge clk); #1;
    check1("reset hold clear", 4'd0);
    j1 = 1'b1; k1 = 1'b0;
    @(posedge clk); #1;
    check1("reset hold set", 4'd0);

    // Release and run the scalar table.
    @(negedge clk);
    rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      j1 = v1[i].j[0]; k1 = v1[i].k[0];
      @(posedge clk); #1;
      check1($sformatf("table1[%0d]", i), v1[i].exp_q);
      @(negedge clk);
    end

    // 4-bit table.
    for (int i = 0; i < 6; i++) begin
      j4 = v4[i].j; k4 = v4[i].k;
      @(posedge clk); #1;
      check($sformatf("table4[%0d] q", i), q4, v4[i].exp_q);
      check($sformatf("table4[%0d] qb", i), qb4, ~v4[i].exp_q);
      @(negedge clk);
    end

    // Reset raised at the same edge that would load 1010: reset must win.
    j4 = 4'b1010; k4 = 4'b0110;
    @(posedge clk);
    rst4 = 1'b1;
    #1;
    check("reset at edge q", q4, 4'b0000);
    check("reset at edge qb", qb4, 4'b1111);
    @(negedge clk);
    rst4 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;

`ifdef JK_FF_S_TOGGLE_CNT_EN
    // Counter with CNT_W=2: five toggles give 1,2,3,0,1; hold leaves it alone.
    rst1 = 1'b1;
    #1;
    check("cnt after reset", {2'b00, cnt1}, 4'd0);
    @(negedge clk);
    rst1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("cnt toggle %0d", i), {2'b00, cnt1}, 4'((i + 1) % 4));
    end
    @(negedge clk);
    j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("cnt hold %0d", i), {2'b00, cnt1}, 4'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
